// File: rtl/change_dispenser.sv
// Change dispenser: releases the product, then ejects change coins one at a time.
// Optional hopper-acknowledge watchdog enabled by defining DISPENSE_TIMEOUT_EN.
module change_dispenser #(
  parameter int MAX_CHANGE  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  input  logic [3:0] r,
  input  logic       coin_ack,
  output logic       vend,
  output logic       coin_out,
  output logic       busy,
  output logic [3:0] change_left,
  output logic       done,
  output logic       err,
  output logic       fault
);

`ifdef DISPENSE_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_VEND, S_PAY, S_GAP, S_DONE, S_FAULT
  } state_t;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_VEND, S_PAY, S_GAP, S_DONE
  } state_t;
`endif

  localparam logic [3:0] MAXC = 4'(MAX_CHANGE);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       d_q;
  logic       req;
  logic       slot_req;
  logic [3:0] r_clamp;

  assign req         = d & ~d_q;
  assign r_clamp     = (r > MAXC) ? MAXC : r;
  assign change_left = cnt_q;
  assign err         = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    pend_d   = pend_q;
    err_d    = err_q;
    slot_req = 1'b0;
    vend     = 1'b0;
    coin_out = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    fault    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          state_d = S_VEND;
          cnt_d   = r_clamp;
        end
      end
      S_VEND: begin
        vend     = 1'b1;
        slot_req = req;
        state_d  = (cnt_q == 4'd0) ? S_DONE : S_PAY;
      end
      S_PAY: begin
        coin_out = 1'b1;
        slot_req = req;
        if (coin_ack) begin
          cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          state_d = S_GAP;
        end
`ifdef DISPENSE_TIMEOUT_EN
        else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end
`endif
      end
      S_GAP: begin
        slot_req = req;
        state_d  = (cnt_q == 4'd0) ? S_DONE : S_PAY;
      end
      S_DONE: begin
        done = 1'b1;
        // With an empty slot a new request starts the next sale directly.
        slot_req = req & pend_q;
        if (pend_q) begin
          state_d = S_VEND;
          cnt_d   = pcnt_q;
          pend_d  = 1'b0;
        end else if (req) begin
          state_d = S_VEND;
          cnt_d   = r_clamp;
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef DISPENSE_TIMEOUT_EN
      S_FAULT: begin
        fault  = 1'b1;
        pend_d = 1'b0;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (slot_req) begin
      if (!pend_q || state_q == S_DONE) begin
        pend_d = 1'b1;
        pcnt_d = r_clamp;
      end else begin
        err_d = 1'b1;
      end
    end
  end

`ifdef DISPENSE_TIMEOUT_EN
  always_comb begin
    tmo_d = '0;
    if (state_q == S_PAY && state_d == S_PAY) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pcnt_q  <= 4'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      d_q     <= d;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized sales
// against a sale-level queue model and a simple hopper responder.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       d;
  logic [3:0] r;
  logic       coin_ack = 1'b0;
  logic       vend, coin_out, busy, done, err, fault;
  logic [3:0] change_left;

  int total = 0;
  int bad   = 0;

  change_dispenser dut (
    .clk(clk), .reset(reset), .d(d), .r(r),
    .coin_ack(coin_ack), .vend(vend), .coin_out(coin_out),
    .busy(busy), .change_left(change_left), .done(done),
    .err(err), .fault(fault)
  );

  always #5 clk = ~clk;

  // Hopper: acks a held eject request after a fixed or random delay.
  bit hop_en = 0;
  bit hop_rand = 0;
  int hop_delay = 0;
  int hop_wait = 0;
  int cur_delay = 0;

  always @(negedge clk) begin
    if (hop_en && coin_out) begin
      if (hop_wait == 0)
        cur_delay = hop_rand ? int'($urandom_range(3, 0)) : hop_delay;
      coin_ack = (hop_wait >= cur_delay);
      hop_wait++;
    end else begin
      coin_ack = 1'b0;
      hop_wait = 0;
    end
  end

  // Sale monitor: coins per completed sale and change owed at vend.
  int   done_cnt = 0;
  int   coin_total = 0;
  int   cur_coins = 0;
  int   cur_cl = 0;
  bit   prev_co = 0;
  int   obs_coins[$];
  int   obs_cl[$];

  always @(negedge clk) begin
    if (vend) begin
      cur_coins = 0;
      cur_cl = int'(change_left);
    end
    if (coin_out && !prev_co) begin
      cur_coins++;
      coin_total++;
    end
    prev_co = coin_out;
    if (done) begin
      obs_coins.push_back(cur_coins);
      obs_cl.push_back(cur_cl);
      done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] rv);
    d = 1'b1;
    r = rv;
    tick();
    d = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    chk("idle_bound", {31'd0, busy}, 32'd0);
  endtask

  function automatic int clampv(input int v);
    return (v > 4) ? 4 : v;
  endfunction

  task automatic chk_sales(input string tag, input int sb, input int q[$]);
    chk({tag, "_nsales"}, obs_coins.size() - sb, q.size());
    for (int k = 0; k < q.size(); k++) begin
      if (sb + k < obs_coins.size()) begin
        chk({tag, "_coins"}, obs_coins[sb + k], q[k]);
        chk({tag, "_cl"}, obs_cl[sb + k], q[k]);
      end
    end
  endtask

  logic co_tr[0:30];
  logic dn_tr[0:30];

  initial begin
    int base, dbase, sb, rises, low_run, gaps_ok, dn_idx, dn_n;
    int issued, n, v;
    int cl_seq[$];
    int exp_q[$];

    reset = 1'b1;
    d = 1'b0;
    r = 4'd0;
    tick();
    tick();
    chk("rst_outs",
        {22'd0, vend, coin_out, busy, change_left, done, err, fault}, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 0);

    // r=0 sale: vend then done, no coins
    base = coin_total;
    pulse(4'd0);
    chk("r0_vend", {31'd0, vend}, 1);
    chk("r0_cl", {28'd0, change_left}, 0);
    tick();
    chk("r0_done", {30'd0, vend, done}, 32'd1);
    tick();
    chk("r0_idle", {31'd0, busy}, 0);
    chk("r0_nocoin", coin_total - base, 0);

    // r=3, ack two cycles after each eject rise
    hop_en = 1;
    hop_rand = 0;
    hop_delay = 2;
    pulse(4'd3);
    chk("r3_vend", {31'd0, vend}, 1);
    cl_seq.delete();
    cl_seq.push_back(int'(change_left));
    co_tr[0] = coin_out;
    dn_tr[0] = done;
    for (int i = 1; i <= 30; i++) begin
      tick();
      co_tr[i] = coin_out;
      dn_tr[i] = done;
      if (int'(change_left) != cl_seq[$])
        cl_seq.push_back(int'(change_left));
    end
    rises = 0;
    low_run = 0;
    gaps_ok = 1;
    dn_n = 0;
    dn_idx = -1;
    for (int i = 0; i <= 30; i++) begin
      if (co_tr[i] && (i == 0 || !co_tr[i-1])) begin
        rises++;
        if (rises > 1 && low_run != 1) gaps_ok = 0;
      end
      if (!co_tr[i]) low_run++;
      else low_run = 0;
      if (dn_tr[i]) begin
        dn_n++;
        dn_idx = i;
      end
    end
    chk("r3_rises", rises, 3);
    chk("r3_gaps", gaps_ok, 1);
    chk("r3_done_n", dn_n, 1);
    chk("r3_done_at", dn_idx, 1 + 3 * (2 + 2));
    chk("r3_cl_n", cl_seq.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < cl_seq.size()) chk("r3_cl_step", cl_seq[k], 3 - k);

    // d held 5 cycles with r=9: one clamped sale
    hop_delay = 0;
    base = coin_total;
    dbase = done_cnt;
    d = 1'b1;
    r = 4'd9;
    tick();
    chk("hold_cl", {28'd0, change_left}, 4);
    repeat (4) tick();
    d = 1'b0;
    wait_idle(100);
    chk("hold_coins", coin_total - base, 4);
    chk("hold_dones", done_cnt - dbase, 1);
    chk("hold_err", {31'd0, err}, 0);

    // request lands on the cycle DONE frees the slot
    hop_delay = 1;
    sb = obs_coins.size();
    pulse(4'd1);
    tick();
    pulse(4'd2);
    tick();
    tick();
    chk("swap_done", {31'd0, done}, 1);
    pulse(4'd3);
    wait_idle(200);
    chk("swap_err", {31'd0, err}, 0);
    exp_q = '{1, 2, 3};
    chk_sales("swap", sb, exp_q);

    // pending slot full: third request dropped
    hop_delay = 3;
    sb = obs_coins.size();
    pulse(4'd2);
    tick();
    pulse(4'd1);
    tick();
    pulse(4'd2);
    wait_idle(200);
    chk("ovr_err", {31'd0, err}, 1);
    exp_q = '{2, 1};
    chk_sales("ovr", sb, exp_q);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovr_clr", {31'd0, err}, 0);

    // reset in PAY with two coins owed
    hop_en = 0;
    pulse(4'd2);
    tick();
    chk("mid_pay", {27'd0, coin_out, change_left}, 32'h12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst",
        {22'd0, vend, coin_out, busy, change_left, done, err, fault}, 0);
    hop_en = 1;
    hop_delay = 1;
    sb = obs_coins.size();
    pulse(4'd1);
    wait_idle(100);
    exp_q = '{1};
    chk_sales("fresh", sb, exp_q);

`ifdef DISPENSE_TIMEOUT_EN
    hop_en = 0;
    pulse(4'd1);
    tick();
    n = 0;
    while (!fault && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_delay", n, 15);
    chk("tmo_outs", {30'd0, coin_out, busy}, 32'd1);
    base = done_cnt;
    pulse(4'd2);
    repeat (3) tick();
    chk("tmo_ignore", {30'd0, fault, busy}, 32'd3);
    chk("tmo_nodone", done_cnt - base, 0);
`else
    hop_en = 0;
    pulse(4'd1);
    repeat (20) tick();
    chk("nof_fault", {31'd0, fault}, 0);
    chk("nof_wait", {31'd0, coin_out}, 1);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // randomized sales, at most one queued behind the active one
    hop_en = 1;
    hop_rand = 1;
    sb = obs_coins.size();
    dbase = done_cnt;
    issued = 0;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(5, 0)) tick();
      n = 0;
      while ((issued - (done_cnt - dbase)) >= 2 && n < 500) begin
        tick();
        n++;
      end
      v = int'($urandom_range(15, 0));
      exp_q.push_back(clampv(v));
      pulse(4'(v));
      issued++;
      tick();
    end
    wait_idle(2000);
    chk("rnd_err", {31'd0, err}, 0);
    chk_sales("rnd", sb, exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter MAX_CHANGE, default 4, giving the largest change count dispensed per sale; larger requests are clamped to it.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 15, giving the cycles to wait for coin_ack, used only with DISPENSE_TIMEOUT_EN.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port d, input, 1 bit, the dispense indication from the upstream vending FSM.
REQ-006 The block SHALL have port r, input, 4 bits, the change count in 1-unit coins, valid while d is high.
REQ-007 The block SHALL have port coin_ack, input, 1 bit, the hopper acknowledge that one coin has been ejected.
REQ-008 The block SHALL have port vend, output, 1 bit, a one-cycle product-release pulse.
REQ-009 The block SHALL have port coin_out, output, 1 bit, the hopper eject request, held until acknowledged.
REQ-010 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-011 The block SHALL have port change_left, output, 4 bits, the coins still owed.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a sale is complete.
REQ-013 The block SHALL have port err, output, 1 bit, sticky overrun flag.
REQ-014 The block SHALL have port fault, output, 1 bit, sticky hopper-timeout flag; it is tied 0 without the macro.

Function
REQ-015 A sale request SHALL be the rising edge of d (d=1 and registered d_q=0); d held high across cycles SHALL count as one request.
REQ-016 On a request, the block SHALL capture cnt = min(r, MAX_CHANGE) in the same cycle.
REQ-017 The state machine SHALL have the states IDLE, VEND, PAY, GAP, DONE, and FAULT (FAULT exists only with the macro).
REQ-018 IDLE SHALL go to VEND on a request, so a request sampled at edge N gives vend=1 during cycle N+1.
REQ-019 VEND SHALL assert vend for exactly one cycle, then go to DONE if cnt==0, else to PAY.
REQ-020 In PAY, coin_out SHALL be 1; when coin_ack=1, cnt SHALL decrement by 1 and the state SHALL go to GAP.
REQ-021 GAP SHALL hold coin_out at 0 for one cycle, then go to DONE if cnt==0, else to PAY.
REQ-022 DONE SHALL assert done for one cycle, then go to VEND if a request is pending, else to IDLE.
REQ-023 coin_ack SHALL be ignored in every state except PAY.
REQ-024 change_left SHALL equal cnt; it SHALL never underflow and SHALL be 0 in IDLE.
REQ-025 Outputs vend, coin_out, busy, and done SHALL be Moore-decoded from the current state only.
REQ-026 A request arriving while busy SHALL be stored in a one-deep pending slot (flag plus clamped r).
REQ-027 A request arriving while the pending slot is full SHALL be dropped and SHALL set err=1 until reset.
REQ-028 A request in the same cycle that DONE consumes the pending slot SHALL occupy the freed slot and SHALL NOT set err.

Reset
REQ-029 When reset=1 at a clock edge, the state SHALL become IDLE and cnt, pending, and d_q SHALL clear.
REQ-030 On that reset edge, vend, coin_out, busy, change_left, done, err, and fault SHALL all become 0.
REQ-031 Reset mid-sale (any state) SHALL abandon the sale; owed coins are not dispensed.
REQ-032 Reset SHALL take priority over a request, coin_ack, and timeout in the same cycle.

Configuration
REQ-033 With DISPENSE_TIMEOUT_EN defined, a counter SHALL count cycles spent in PAY and SHALL clear on entry to PAY.
REQ-034 With DISPENSE_TIMEOUT_EN defined, if the PAY counter reaches ACK_TIMEOUT without coin_ack, the state SHALL go to FAULT.
REQ-035 In FAULT, fault=1 and busy=1, coin_out=0, pending SHALL be cleared, and requests SHALL be ignored until reset.
REQ-036 With DISPENSE_TIMEOUT_EN defined, coin_ack on the timeout cycle SHALL win: the coin is counted and no FAULT occurs.
REQ-037 Without DISPENSE_TIMEOUT_EN, PAY SHALL wait indefinitely, there is no FAULT state or counter, and fault SHALL be constant 0.

Verification
REQ-038 A 1-cycle pulse on d with r=0 SHALL give vend one cycle later, then done the next cycle, and coin_out SHALL never rise.
REQ-039 d pulsed with r=3 and coin_ack returned 2 cycles after each coin_out rise SHALL give exactly 3 coin_out assertions, each separated by a 1-cycle gap.
REQ-040 In the REQ-039 case, change_left SHALL step 3,2,1,0, and done SHALL occur once.
REQ-041 d held high for 5 cycles with r=9 SHALL be one sale with change_left=4 (clamped) and exactly 4 coins dispensed.
REQ-042 During a sale with r=2, two further d pulses (r=1, then r=2) SHALL dispense the first queued sale (1 coin) after the current sale's done.
REQ-043 In the REQ-042 case, the third request SHALL be dropped and err SHALL be 1.
REQ-044 Reset asserted while in PAY with change_left=2 SHALL give all outputs 0 next cycle, and a later d pulse SHALL start a fresh sale normally.
REQ-045 With DISPENSE_TIMEOUT_EN defined and coin_ack held 0, fault SHALL rise 15 cycles after coin_out rises, with coin_out=0 and d ignored until reset.
